// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: issue/result bus between the EX-stage decode path and the multiply/divide controller
//   start/op/src_a/src_b/flush : issuer -> controller
//   stall/busy/done/hi/lo      : controller -> issuer
interface mdu_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, src_a, src_b, flush, input stall, busy, done, hi, lo);
  modport slave  (input start, op, src_a, src_b, flush, output stall, busy, done, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer producing the {hi,lo} result and a pipeline stall
//   clk    : core clock
//   resetn : synchronous active-low reset
//   m      : slave side of mdu_ctrl_if (start/op/src_a/src_b/flush in; stall/busy/done/hi/lo out)
module mdu_ctrl #(
  parameter int DIV_ITERS = 32
) (
  input logic clk,
  input logic resetn,
  mdu_ctrl_if.slave m
);
  localparam int CW = $clog2(DIV_ITERS);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] op_q;
  logic [31:0] a_q, b_q, quo, rem, b_mag, quo_n, rem_n;
  logic [32:0] shl;
  logic signed [32:0] ma, mb;
  logic signed [63:0] prod;
  logic [63:0] res;
  logic accept, sgn, ge, last;
  assign sgn = ~op_q[0];
  assign accept = state == IDLE && m.start && !m.flush;
  assign last = cnt == CW'(DIV_ITERS - 1);
  assign m.busy = state == MUL || state == DIV;
  assign m.done = state == DONE;
  assign m.stall = accept || m.busy;
  always_comb begin
    b_mag = sgn && b_q[31] ? -b_q : b_q;
    shl = {rem, quo[31]};
    ge = shl >= {1'b0, b_mag};
    rem_n = ge ? 32'(shl - {1'b0, b_mag}) : shl[31:0];
    quo_n = {quo[30:0], ge};
    ma = {sgn & a_q[31], a_q};
    mb = {sgn & b_q[31], b_q};
    prod = 64'(ma) * 64'(mb);
    // divide by zero bypasses sign fix-up: hi returns the raw dividend
    res = !op_q[1] ? prod :
          b_q == '0 ? {a_q, 32'hFFFF_FFFF} :
          {sgn && a_q[31] ? -rem_n : rem_n, sgn && (a_q[31] ^ b_q[31]) ? -quo_n : quo_n};
    state_n = m.flush ? IDLE :
              state == IDLE ? (m.start ? (m.op[1] ? DIV : MUL) : IDLE) :
              state == MUL ? DONE :
              state == DIV ? (last ? DONE : DIV) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      quo <= '0;
      rem <= '0;
      m.hi <= '0;
      m.lo <= '0;
    end else begin
      state <= state_n;
      cnt <= state == DIV && !m.flush ? cnt + CW'(1) : '0;
      if (accept) begin
        op_q <= m.op;
        a_q <= m.src_a;
        b_q <= m.src_b;
        quo <= !m.op[0] && m.src_a[31] ? -m.src_a : m.src_a;
        rem <= '0;
      end
      if (state == DIV) begin
        rem <= rem_n;
        quo <= quo_n;
      end
      if (state_n == DONE) {m.hi, m.lo} <= res;
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  mdu_ctrl_if bus();
  mdu_ctrl dut (.clk(clk), .resetn(resetn), .m(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int lat, input logic [31:0] eh, input logic [31:0] el);
    int n;
    bus.op = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    #1;
    chk({tag, " stall_accept"}, bus.stall, 1);
    tick;
    bus.start = 1'b0;
    #1;
    chk({tag, " busy_k1"}, bus.busy, 1);
    chk({tag, " stall_k1"}, bus.stall, 1);
    n = 1;
    while (!bus.done && n < 40) begin
      tick;
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " stall_done"}, bus.stall, 0);
    chk({tag, " hi"}, bus.hi, eh);
    chk({tag, " lo"}, bus.lo, el);
    tick;
    chk({tag, " done_pulse"}, bus.done, 0);
  endtask
  initial begin
    int dones, busys;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
    #1;
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst stall", bus.stall, 0);
    chk("rst hilo", {bus.hi, bus.lo}, 64'h0);
    tick;
    run("mult", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
    run("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
    run("div_mix", 2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 33, 32'h0000_0002, 32'hFFFF_FFF2);
    run("divu_zero", 2'b11, 32'h0000_1234, 32'h0000_0000, 33, 32'h0000_1234, 32'hFFFF_FFFF);
    // flush mid-divide at cycle k+10
    bus.op = 2'b10;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    bus.flush = 1'b1;
    #1;
    chk("flush busy_same", bus.busy, 1);
    tick;
    bus.flush = 1'b0;
    #1;
    chk("flush busy_after", bus.busy, 0);
    chk("flush stall_after", bus.stall, 0);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) dones++;
      tick;
    end
    chk("flush no_done", dones, 0);
    chk("flush hilo_kept", {bus.hi, bus.lo}, 64'h0000_1234_FFFF_FFFF);
    // flush in idle blocks acceptance combinationally
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #1;
    chk("flush_idle stall", bus.stall, 0);
    tick;
    chk("flush_idle busy", bus.busy, 0);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    tick;
    run("divu_100_7", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    // flush during DONE: pulse already out, result stands
    bus.op = 2'b01;
    bus.src_a = 32'd6;
    bus.src_b = 32'd7;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    bus.flush = 1'b1;
    #1;
    chk("flush_done done", bus.done, 1);
    tick;
    bus.flush = 1'b0;
    chk("flush_done hilo", {bus.hi, bus.lo}, 64'd42);
    // continuous start: accept every third cycle
    bus.op = 2'b01;
    bus.src_a = 32'd3;
    bus.src_b = 32'd4;
    bus.start = 1'b1;
    dones = 0;
    busys = 0;
    for (int i = 0; i < 9; i++) begin
      tick;
      if (bus.done) begin
        dones++;
        chk("stream stall_done", bus.stall, 0);
      end
      if (bus.busy) busys++;
    end
    bus.start = 1'b0;
    chk("stream dones", dones, 3);
    chk("stream accepts", busys, 3);
    chk("stream lo", bus.lo, 32'd12);
    tick;
    tick;
    // reset mid-divide
    bus.op = 2'b10;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    resetn = 1'b0;
    tick;
    chk("rst_mid busy", bus.busy, 0);
    chk("rst_mid done", bus.done, 0);
    chk("rst_mid stall", bus.stall, 0);
    chk("rst_mid hilo", {bus.hi, bus.lo}, 64'h0);
    resetn = 1'b1;
    tick;
    run("mult_after_rst", 2'b00, 32'h0000_0007, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
